iob_pbus_merge: RTL and testbench
=================================

Name: iob_pbus_merge

Overview:
- Two-manager to one-subordinate IOb native-bus arbiter/merge; sits directly upstream of the peripheral-bus split and drives its subordinate port.
- Round-robin grant, locked from request acceptance until the transaction completes: ready for writes, rvalid for reads.
- Zero-latency pass-through of the granted request.

Parameters:
ADDR_W, 14, address width on all ports (matches split subordinate address width)
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk_i  in  1  clock, rising edge
cke_i  in  1  clock enable; when 0, all registers hold
rst_n_i  in  1  reset; one clock, reset is synchronous and active-low
s0_iob_valid_i  in  1  manager 0 request valid
s0_iob_addr_i  in  ADDR_W  manager 0 address
s0_iob_wdata_i  in  DATA_W  manager 0 write data
s0_iob_wstrb_i  in  DATA_W/8  manager 0 write strobe; 0 means read
s0_iob_rvalid_o  out  1  manager 0 read data valid
s0_iob_rdata_o  out  DATA_W  manager 0 read data
s0_iob_ready_o  out  1  manager 0 request accepted
s1_iob_*  (same seven signals as s0)  manager 1 port
m_iob_valid_o  out  1  merged request valid, to split
m_iob_addr_o  out  ADDR_W  merged address
m_iob_wdata_o  out  DATA_W  merged write data
m_iob_wstrb_o  out  DATA_W/8  merged write strobe
m_iob_rvalid_i  in  1  downstream read data valid
m_iob_rdata_i  in  DATA_W  downstream read data
m_iob_ready_i  in  1  downstream request accepted

Behaviour:
Registers:
- state: 2 bits, reset IDLE.
- gnt: 1 bit, currently granted manager, reset 0.
- last: 1 bit, last served manager, reset 1, so s0 wins the first tie.
- All registers update only when cke_i=1. Reset is applied at a clock edge when rst_n_i=0 and cke_i=1.

Combinational output forcing:
- While rst_n_i=0: m_iob_valid_o=0, all s*_ready_o=0, all s*_rvalid_o=0.
- These are also the effective post-reset values.

Grant selection in IDLE (combinational, sel):
- Only one valid: that manager.
- Both valid: the manager not equal to last.
- Neither valid: sel=gnt.

Routing, with src=sel in IDLE and src=gnt otherwise:
- m_iob_valid_o = src valid, in IDLE and WAIT_READY only; 0 in WAIT_RVALID.
- m_iob_addr_o, m_iob_wdata_o, m_iob_wstrb_o = src fields in all states.
- Non-src manager: ready_o=0, rvalid_o=0.
- src ready_o = m_iob_ready_i, in IDLE and WAIT_READY only.
- src rvalid_o = m_iob_rvalid_i, in WAIT_RVALID, and in IDLE/WAIT_READY in the cycle ready is returned.
- s0_iob_rdata_o = s1_iob_rdata_o = m_iob_rdata_i, broadcast; meaningful only with rvalid.

FSM: IDLE, WAIT_READY, WAIT_RVALID.
- IDLE, no valid: stay.
- IDLE, valid: gnt<=sel, then:
  - ready & write (|wstrb): stay IDLE, last<=sel.
  - ready & read & rvalid: stay IDLE, last<=sel.
  - ready & read & !rvalid: go to WAIT_RVALID.
  - !ready: go to WAIT_READY.
- WAIT_READY: grant locked; the other manager's valid is ignored (its ready stays 0).
  - ready & write: go to IDLE, last<=gnt.
  - ready & read & rvalid: go to IDLE, last<=gnt.
  - ready & read: go to WAIT_RVALID.
  - Otherwise stay.
- WAIT_RVALID:
  - rvalid: go to IDLE, last<=gnt.
  - Otherwise stay.

Timing and boundary conditions:
- Latency: zero combinational latency from s valid to m valid. Zero added latency on ready, rvalid and rdata.
- Managers hold valid and payload until ready (IOb rule); the block does not register payload.
- A losing manager with valid held is served next; no starvation, maximum wait is one transaction.
- A new request is accepted in the same cycle a previous one completes only from IDLE; there is no overlap of outstanding reads.
- Reset mid-transaction: state returns to IDLE and the outstanding transaction is abandoned. A late m_iob_rvalid_i arriving in IDLE with no valid asserted is dropped (it is routed to sel=gnt only when that manager's valid is 1).
- cke_i=0: state, gnt and last hold; combinational routing stays active.

Test Plan:
1. Reset: rst_n_i=0 for 2 cycles with s0 valid=1 -> m_iob_valid_o=0, s0_ready=0. Release -> m_valid=1 in the same cycle as s0 valid.
2. Single write: s0 valid, addr=0x0123, wdata=0xDEADBEEF, wstrb=0xF, m_ready=1 -> m fields equal s0 fields, s0_ready=1 in the same cycle, state stays IDLE, last=0.
3. Tie: s0 and s1 both valid writes, m_ready=1 every cycle -> cycle 0 serves s0 with s1_ready=0; cycle 1 serves s1; repeated ties alternate 0,1,0,1.
4. Read with delay: s1 read addr=0x2004, m_ready=0 for 2 cycles, then 1, rvalid 3 cycles later with rdata=0xCAFEF00D -> s1_rvalid=1, s1_rdata=0xCAFEF00D; s0 valid during this time sees ready=0 and is served immediately after.
5. Same-cycle ready and rvalid on an s0 read -> completes in 1 cycle, no WAIT_RVALID.
6. rst_n_i=0 while in WAIT_RVALID -> next cycle IDLE; a subsequent rvalid with no valid asserted produces no s*_rvalid_o pulse.

Source files
------------

// File: rtl/iob_pbus_merge.sv
// iob_pbus_merge: two-manager to one-subordinate IOb native-bus merge.
// Round-robin arbitration; the grant is locked from request acceptance until
// the transaction completes (ready for writes, rvalid for reads). The granted
// request passes through combinationally, with no payload registers.
module iob_pbus_merge #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                cke_i,
    input  logic                rst_n_i,
    // manager 0
    input  logic                s0_iob_valid_i,
    input  logic [ADDR_W-1:0]   s0_iob_addr_i,
    input  logic [DATA_W-1:0]   s0_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s0_iob_wstrb_i,
    output logic                s0_iob_rvalid_o,
    output logic [DATA_W-1:0]   s0_iob_rdata_o,
    output logic                s0_iob_ready_o,
    // manager 1
    input  logic                s1_iob_valid_i,
    input  logic [ADDR_W-1:0]   s1_iob_addr_i,
    input  logic [DATA_W-1:0]   s1_iob_wdata_i,
    input  logic [DATA_W/8-1:0] s1_iob_wstrb_i,
    output logic                s1_iob_rvalid_o,
    output logic [DATA_W-1:0]   s1_iob_rdata_o,
    output logic                s1_iob_ready_o,
    // merged subordinate port
    output logic                m_iob_valid_o,
    output logic [ADDR_W-1:0]   m_iob_addr_o,
    output logic [DATA_W-1:0]   m_iob_wdata_o,
    output logic [DATA_W/8-1:0] m_iob_wstrb_o,
    input  logic                m_iob_rvalid_i,
    input  logic [DATA_W-1:0]   m_iob_rdata_i,
    input  logic                m_iob_ready_i
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_READY  = 2'd1,
        WAIT_RVALID = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q,   gnt_d;
    logic   last_q,  last_d;

    logic                sel;
    logic                src;
    logic                src_valid;
    logic                src_write;
    logic                req_phase;
    logic                ready_fwd;
    logic                rvalid_fwd;

    // Arbitration: a lone requester wins; on a tie the manager not served last
    // wins; with no request the grant is left where it was.
    always_comb begin
        sel = gnt_q;
        if (s0_iob_valid_i && !s1_iob_valid_i) begin
            sel = 1'b0;
        end else if (s1_iob_valid_i && !s0_iob_valid_i) begin
            sel = 1'b1;
        end else if (s0_iob_valid_i && s1_iob_valid_i) begin
            sel = ~last_q;
        end
    end

    // Request routing: the fresh arbitration result in IDLE, the locked grant
    // otherwise. Payload is muxed in every state; only valid is gated.
    always_comb begin
        src       = (state_q == IDLE) ? sel : gnt_q;
        req_phase = (state_q != WAIT_RVALID);
        if (src) begin
            src_valid     = s1_iob_valid_i;
            m_iob_addr_o  = s1_iob_addr_i;
            m_iob_wdata_o = s1_iob_wdata_i;
            m_iob_wstrb_o = s1_iob_wstrb_i;
        end else begin
            src_valid     = s0_iob_valid_i;
            m_iob_addr_o  = s0_iob_addr_i;
            m_iob_wdata_o = s0_iob_wdata_i;
            m_iob_wstrb_o = s0_iob_wstrb_i;
        end
        src_write = |m_iob_wstrb_o;
    end

    // Response routing. During reset everything handshake-related is forced
    // low. A read response outside WAIT_RVALID is only forwarded together
    // with the ready of a live request, so a stale rvalid arriving in IDLE
    // after an abandoned transaction is dropped.
    always_comb begin
        m_iob_valid_o   = rst_n_i && req_phase && src_valid;
        ready_fwd       = rst_n_i && req_phase && m_iob_ready_i;
        rvalid_fwd      = rst_n_i && m_iob_rvalid_i &&
                          (!req_phase || (src_valid && m_iob_ready_i));
        s0_iob_ready_o  = ready_fwd  && !src;
        s1_iob_ready_o  = ready_fwd  &&  src;
        s0_iob_rvalid_o = rvalid_fwd && !src;
        s1_iob_rvalid_o = rvalid_fwd &&  src;
        s0_iob_rdata_o  = m_iob_rdata_i;
        s1_iob_rdata_o  = m_iob_rdata_i;
    end

    // Next-state logic: lock the grant on acceptance and record the served
    // manager in last when its transaction completes.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (src_valid) begin
                    gnt_d = sel;
                    if (m_iob_ready_i) begin
                        if (src_write || m_iob_rvalid_i) begin
                            last_d = sel;
                        end else begin
                            state_d = WAIT_RVALID;
                        end
                    end else begin
                        state_d = WAIT_READY;
                    end
                end
            end
            WAIT_READY: begin
                if (m_iob_ready_i) begin
                    if (src_write || m_iob_rvalid_i) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end else begin
                        state_d = WAIT_RVALID;
                    end
                end
            end
            WAIT_RVALID: begin
                if (m_iob_rvalid_i) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; clock enable gates both reset and update.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                state_q <= IDLE;
                gnt_q   <= 1'b0;
                last_q  <= 1'b1;
            end else begin
                state_q <= state_d;
                gnt_q   <= gnt_d;
                last_q  <= last_d;
            end
        end
    end

endmodule

// File: tb/tb_iob_pbus_merge.sv
// Directed bench for iob_pbus_merge: reset, writes, tie alternation, delayed
// read, same-cycle read completion, reset during a read, and clock enable.
module tb_iob_pbus_merge;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int SW     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              cke, rst_n;
    logic              s0_valid, s1_valid;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic [DATA_W-1:0] s0_wdata, s1_wdata;
    logic [SW-1:0]     s0_wstrb, s1_wstrb;
    logic              s0_rvalid, s1_rvalid, s0_ready, s1_ready;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;
    logic              m_valid;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_rvalid, m_ready;
    logic [DATA_W-1:0] m_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_pbus_merge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
        .s0_iob_valid_i(s0_valid), .s0_iob_addr_i(s0_addr),
        .s0_iob_wdata_i(s0_wdata), .s0_iob_wstrb_i(s0_wstrb),
        .s0_iob_rvalid_o(s0_rvalid), .s0_iob_rdata_o(s0_rdata),
        .s0_iob_ready_o(s0_ready),
        .s1_iob_valid_i(s1_valid), .s1_iob_addr_i(s1_addr),
        .s1_iob_wdata_i(s1_wdata), .s1_iob_wstrb_i(s1_wstrb),
        .s1_iob_rvalid_o(s1_rvalid), .s1_iob_rdata_o(s1_rdata),
        .s1_iob_ready_o(s1_ready),
        .m_iob_valid_o(m_valid), .m_iob_addr_o(m_addr),
        .m_iob_wdata_o(m_wdata), .m_iob_wstrb_o(m_wstrb),
        .m_iob_rvalid_i(m_rvalid), .m_iob_rdata_i(m_rdata),
        .m_iob_ready_i(m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks happen mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        cke = 1'b1; rst_n = 1'b0;
        s0_valid = 1'b1; s0_addr = 14'h0123; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
        s1_valid = 1'b0; s1_addr = '0; s1_wdata = '0; s1_wstrb = '0;
        m_rvalid = 1'b0; m_rdata = '0; m_ready = 1'b1;

        // reset with s0 requesting: all handshakes forced low
        #1; settle();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_s0_ready", 32'(s0_ready), 32'd0);
        chk("rst_s0_rvalid", 32'(s0_rvalid), 32'd0);
        tick(); settle();
        chk("rst2_m_valid", 32'(m_valid), 32'd0);
        tick();

        // release: s0 valid passes through in the same cycle, held off by !ready
        rst_n = 1'b1; m_ready = 1'b0; settle();
        chk("rel_m_valid", 32'(m_valid), 32'd1);
        chk("rel_s0_ready", 32'(s0_ready), 32'd0);
        tick();

        // single write completes from WAIT_READY
        m_ready = 1'b1; settle();
        chk("wr_m_addr", 32'(m_addr), 32'h0123);
        chk("wr_m_wdata", m_wdata, 32'hDEADBEEF);
        chk("wr_m_wstrb", 32'(m_wstrb), 32'hF);
        chk("wr_s0_ready", 32'(s0_ready), 32'd1);
        chk("wr_s1_ready", 32'(s1_ready), 32'd0);
        tick();

        // ties: last=0 now, so s1 first, then alternate
        s1_valid = 1'b1; s1_addr = 14'h0456; s1_wdata = 32'h11111111; s1_wstrb = 4'h3;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (i % 2 == 0) begin
                chk("tie_m_addr", 32'(m_addr), 32'h0456);
                chk("tie_s1_ready", 32'(s1_ready), 32'd1);
                chk("tie_s0_ready", 32'(s0_ready), 32'd0);
            end else begin
                chk("tie_m_addr", 32'(m_addr), 32'h0123);
                chk("tie_s0_ready", 32'(s0_ready), 32'd1);
                chk("tie_s1_ready", 32'(s1_ready), 32'd0);
            end
            tick();
        end

        // delayed read on s1 (wins tie, last=0); s0 write waits
        s1_addr = 14'h2004; s1_wstrb = 4'h0; m_ready = 1'b0; settle();
        chk("rd_m_addr", 32'(m_addr), 32'h2004);
        chk("rd_s0_ready_a", 32'(s0_ready), 32'd0);
        tick(); settle();
        chk("rd_lock_m_addr", 32'(m_addr), 32'h2004);
        chk("rd_s0_ready_b", 32'(s0_ready), 32'd0);
        tick();
        m_ready = 1'b1; settle();
        chk("rd_s1_ready", 32'(s1_ready), 32'd1);
        chk("rd_s0_ready_c", 32'(s0_ready), 32'd0);
        chk("rd_s1_rvalid_early", 32'(s1_rvalid), 32'd0);
        tick();
        s1_valid = 1'b0; m_ready = 1'b0; settle();
        chk("rd_wait_m_valid", 32'(m_valid), 32'd0);
        tick(); settle();
        chk("rd_wait_s1_rvalid", 32'(s1_rvalid), 32'd0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; settle();
        chk("rd_s1_rvalid", 32'(s1_rvalid), 32'd1);
        chk("rd_s1_rdata", s1_rdata, 32'hCAFEF00D);
        chk("rd_s0_rvalid", 32'(s0_rvalid), 32'd0);
        tick();
        m_rvalid = 1'b0; m_ready = 1'b1; settle();
        chk("after_rd_m_addr", 32'(m_addr), 32'h0123);
        chk("after_rd_s0_ready", 32'(s0_ready), 32'd1);
        tick();

        // s0 read with ready and rvalid together: one-cycle completion
        s0_addr = 14'h0010; s0_wstrb = 4'h0; m_rvalid = 1'b1; m_rdata = 32'h12345678; settle();
        chk("fast_s0_ready", 32'(s0_ready), 32'd1);
        chk("fast_s0_rvalid", 32'(s0_rvalid), 32'd1);
        chk("fast_s0_rdata", s0_rdata, 32'h12345678);
        tick();
        m_rvalid = 1'b0; s0_addr = 14'h0020; s0_wstrb = 4'hF; settle();
        chk("fast_idle_s0_ready", 32'(s0_ready), 32'd1);
        tick();

        // reset while in WAIT_RVALID, then a late rvalid is dropped
        s0_valid = 1'b0; s1_valid = 1'b1; s1_addr = 14'h0030; s1_wstrb = 4'h0; settle();
        chk("r6_s1_ready", 32'(s1_ready), 32'd1);
        tick();
        s1_valid = 1'b0; m_ready = 1'b0; rst_n = 1'b0; settle();
        tick();
        rst_n = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h55AA55AA; settle();
        chk("late_s0_rvalid", 32'(s0_rvalid), 32'd0);
        chk("late_s1_rvalid", 32'(s1_rvalid), 32'd0);
        tick();
        m_rvalid = 1'b0; m_ready = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1; s1_wstrb = 4'hF; settle();
        chk("post_rst_tie_s0", 32'(s0_ready), 32'd1);
        chk("post_rst_tie_s1", 32'(s1_ready), 32'd0);
        tick();

        // cke=0: routing live, registers hold (a read accepted now is not recorded)
        cke = 1'b0; s0_valid = 1'b0; s1_valid = 1'b1; s1_wstrb = 4'h0; settle();
        chk("cke_m_valid", 32'(m_valid), 32'd1);
        chk("cke_s1_ready", 32'(s1_ready), 32'd1);
        tick();
        cke = 1'b1; s1_valid = 1'b0; s0_valid = 1'b1; s0_wstrb = 4'hF; settle();
        chk("cke_hold_s0_ready", 32'(s0_ready), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
